pipe_stall_ctrl: RTL

- Central pipeline control unit that produces the per-register stall codes (Pass/Hold/Bubb) consumed by every inter-stage pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Its inputs are the hazard and status sources: the load-use hazard from the ID/EX boundary, instruction-fetch busy, memory-stage busy, and branch mispredict from EX.
- It contains a post-mispredict flush FSM that discards in-flight fetches for a fixed window.
- It contains saturating stall/flush performance counters.

---
 rtl/pipe_stall_ctrl_pkg.sv | 23 ++
 rtl/pipe_stall_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_stall_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions used by every inter-stage register
// and by the stall controller.
//   stall_e   : per-register stall code (Pass/Hold/Bubb); 2'b11 is unused
//   state_e   : post-mispredict flush FSM state (RUN/FLUSH)
//   STALL_W   : width of one stall code
//   REG_ADDR_W: width of a register-file index
package pipe_stall_ctrl_pkg;

    localparam int STALL_W    = 2;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [STALL_W-1:0] {
        STALL_PASS = 2'b00,
        STALL_HOLD = 2'b01,
        STALL_BUBB = 2'b10
    } stall_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   clk   : clock
//   clear : synchronous clear, wins over inc
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller. Produces the Pass/Hold/Bubb code for
// each inter-stage register from the hazard/status inputs and a small
// post-mispredict flush FSM, and keeps saturating performance counters.
//   clk, rst               : clock, synchronous active-high reset
//   if_busy_i              : fetch has no valid instruction this cycle
//   mem_busy_i             : MEM stage waiting on memory
//   branch_error_i         : EX resolved a mispredict this cycle
//   id_rs*_request_i/addr_i: ID source operand usage and indices
//   ex_rd_load_i/addr_i    : EX instruction is a load, and its destination
//   stall_*_o              : stall code for each stage register
//   flushing_o             : FSM is in FLUSH
//   cnt_hold_o             : cycles held for mem_busy
//   cnt_bubble_o           : load-use bubbles inserted
//   cnt_flush_o            : mispredict flushes started
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_busy_i,
    input  logic                  mem_busy_i,
    input  logic                  branch_error_i,
    input  logic                  id_rs1_request_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic                  id_rs2_request_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  ex_rd_load_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    output logic [STALL_W-1:0]    stall_pc_o,
    output logic [STALL_W-1:0]    stall_if_id_o,
    output logic [STALL_W-1:0]    stall_id_ex_o,
    output logic [STALL_W-1:0]    stall_ex_mem_o,
    output logic [STALL_W-1:0]    stall_mem_wb_o,
    output logic                  flushing_o,
    output logic [CNT_W-1:0]      cnt_hold_o,
    output logic [CNT_W-1:0]      cnt_bubble_o,
    output logic [CNT_W-1:0]      cnt_flush_o
);

    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic   haz;
    logic   bubble_fire;
    logic   flush_fire;
    stall_e pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s;

    // Load-use hazard: the ID instruction needs a value a load in EX has
    // not produced yet. x0 never carries a real dependency.
    assign haz = ex_rd_load_i && (ex_rd_addr_i != '0) &&
                 ((id_rs1_request_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                  (id_rs2_request_i && (id_rs2_addr_i == ex_rd_addr_i)));

    // A held EX keeps branch_error_i asserted, so the mispredict is acted
    // on only once memory releases the pipeline.
    assign flush_fire  = !mem_busy_i && branch_error_i;
    assign bubble_fire = !mem_busy_i && !branch_error_i &&
                         (state_q == ST_RUN) && haz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state. The counter holds the number of FLUSH cycles still to
    // follow the current one; the FSM leaves FLUSH after it reads 0.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (mem_busy_i) begin
            state_d = state_q;
            fcnt_d  = fcnt_q;
        end else if (branch_error_i) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_LOAD;
        end else if (state_q == ST_FLUSH) begin
            if (fcnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                fcnt_d = fcnt_q - 1'b1;
            end
        end
    end

    // Stall codes, highest priority first.
    always_comb begin
        pc_s     = STALL_PASS;
        if_id_s  = STALL_PASS;
        id_ex_s  = STALL_PASS;
        ex_mem_s = STALL_PASS;
        mem_wb_s = STALL_PASS;
        if (rst) begin
            pc_s     = STALL_BUBB;
            if_id_s  = STALL_BUBB;
            id_ex_s  = STALL_BUBB;
            ex_mem_s = STALL_BUBB;
            mem_wb_s = STALL_BUBB;
        end else if (mem_busy_i) begin
            pc_s     = STALL_HOLD;
            if_id_s  = STALL_HOLD;
            id_ex_s  = STALL_HOLD;
            ex_mem_s = STALL_HOLD;
            mem_wb_s = STALL_BUBB;
        end else if (branch_error_i) begin
            // pc passes so the redirect target is taken this edge.
            if_id_s = STALL_BUBB;
            id_ex_s = STALL_BUBB;
        end else if (state_q == ST_FLUSH) begin
            pc_s    = if_busy_i ? STALL_HOLD : STALL_PASS;
            if_id_s = STALL_BUBB;
        end else if (haz) begin
            pc_s    = STALL_HOLD;
            if_id_s = STALL_HOLD;
            id_ex_s = STALL_BUBB;
        end else if (if_busy_i) begin
            pc_s    = STALL_HOLD;
            if_id_s = STALL_BUBB;
        end
    end

    assign stall_pc_o     = pc_s;
    assign stall_if_id_o  = if_id_s;
    assign stall_id_ex_o  = id_ex_s;
    assign stall_ex_mem_o = ex_mem_s;
    assign stall_mem_wb_o = mem_wb_s;
    assign flushing_o     = (state_q == ST_FLUSH) && !rst;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_hold (
        .clk   (clk),
        .clear (rst),
        .inc   (mem_busy_i),
        .count (cnt_hold_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_bubble (
        .clk   (clk),
        .clear (rst),
        .inc   (bubble_fire),
        .count (cnt_bubble_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_fire),
        .count (cnt_flush_o)
    );

endmodule
